program_loader: RTL and testbench

- Byte-stream program loader for the accumulator CPU, the writer side of instruction/data memory.
- Accepts a framed program over a valid/ready byte interface and writes it into memory from address 0.
- Holds the CPU in reset while loading, verifies an XOR checksum, then releases the CPU.
- Drives the CPU `start` input, which resumes execution from the halt opcode (3'b111).

---
 rtl/loader_pkg.sv | 26 ++
 rtl/program_loader_edge_pulse.sv | 22 ++
 rtl/program_loader.sv | 125 ++++++++++++
 tb/tb_program_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states, CPU opcodes and the frame length check.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // A frame may carry between 1 and a full memory (2**addr_w words).
  function automatic logic len_valid(input int unsigned len, input int unsigned addr_w);
    return (len >= 32'd1) && (len <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/program_loader_edge_pulse.sv
// Rising-edge detector: rise_o is high for the cycle in which sig_i is 1 after being 0.
// Combinational output, one register of history; a held input yields a single pulse.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader: length, L words, XOR checksum; writes memory from address 0, then releases the CPU.
// Memory writes and all outputs are registered (1-cycle latency); the stream is never stalled.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              start,
  input  logic              resume_req,
  output logic              busy,
  output logic              err
);

  state_e              state_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   csum_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                cpu_rst_q;
  logic                start_q;
  logic                busy_q;
  logic                err_q;

  logic                xfer;
  logic                len_ok;
  logic                resume_rise;

  // Every state accepts a byte, so the loader never applies backpressure.
  assign in_ready = 1'b1;
  assign xfer     = in_valid & in_ready;
  assign len_ok   = len_valid(32'(in_data), ADDR_W);

  edge_pulse u_resume_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (resume_req),
    .rise_o (resume_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      start_q  <= 1'b0;
      if (xfer) begin
        case (state_q)
          // A byte arriving outside a frame is always a length byte; in RUN it aborts the program.
          S_IDLE, S_RUN, S_ERR: begin
            cpu_rst_q <= 1'b1;
            if (len_ok) begin
              state_q <= S_DATA;
              count_q <= (ADDR_W+1)'(in_data);
              idx_q   <= '0;
              csum_q  <= '0;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          S_DATA: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= idx_q;
            mem_wdata_q <= in_data;
            csum_q      <= csum_q ^ in_data;
            idx_q       <= idx_q + ADDR_W'(1);
            count_q     <= count_q - (ADDR_W+1)'(1);
            if (count_q == (ADDR_W+1)'(1)) begin
              state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            busy_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q   <= S_RUN;
              cpu_rst_q <= 1'b0;
              start_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end else if ((state_q == S_RUN) && resume_rise) begin
        start_q <= 1'b1;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of per-cycle vectors plus multi-cycle sequences.
module tb_program_loader;
  import loader_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       start;
  logic       resume_req;
  logic       busy;
  logic       err;

  program_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .start      (start),
    .resume_req (resume_req),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid   = v;
    in_data    = d;
    resume_req = r;
    @(posedge clk);
    #1;
  endtask

  // Memory model and in-order write checker, sampled on the falling edge.
  logic [7:0] mem_model [32];
  logic [7:0] exp_w [32];
  int         exp_a  = 0;
  int         we_cnt = 0;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem_model[mem_addr] = mem_wdata;
      we_cnt++;
      if (mon_en) begin
        checks++;
        if (exp_a >= 32 || mem_addr !== exp_a[4:0] || mem_wdata !== exp_w[exp_a]) begin
          errors++;
          $display("FAIL write_seq got addr %0d data %0h want addr %0d", mem_addr, mem_wdata, exp_a);
        end
        exp_a++;
      end
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       we;
    logic [4:0] a;
    logic [7:0] wd;
    logic       crst;
    logic       st;
    logic       bsy;
    logic       er;
  } vec_t;

  vec_t       vt [26];
  logic [2:0] ops [8];
  logic [7:0] csum;
  logic [18:0] got_v;
  logic [18:0] exp_v;
  int         pulses;
  int         we_snap;

  initial begin
    ops = '{OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_LDI, OP_HLT};
    //          v   d      r   we  a     wd     crst st  bsy er
    vt[0]  = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 8'h05, 1'b0, 1'b1, 5'd0, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 5'd0, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 8'h46, 1'b0, 1'b1, 5'd1, 8'h46, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 5'd0, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 8'h46, 1'b0, 1'b1, 5'd1, 8'h46, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 8'hE0, 1'b0, 1'b1, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 8'h21, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[15] = '{1'b1, 8'h01, 1'b0, 1'b0, 5'd2, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b1, 8'hE0, 1'b0, 1'b1, 5'd0, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[17] = '{1'b1, 8'hE0, 1'b0, 1'b0, 5'd0, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[22] = '{1'b1, 8'h02, 1'b1, 1'b0, 5'd0, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[23] = '{1'b1, 8'h11, 1'b0, 1'b1, 5'd0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[24] = '{1'b1, 8'h22, 1'b0, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[25] = '{1'b1, 8'h33, 1'b0, 1'b0, 5'd1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    resume_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, start, busy, err},
        {1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(vt[i].v, vt[i].d, vt[i].r);
      got_v = {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, start, busy, err};
      exp_v = {1'b1, vt[i].we, vt[i].a, vt[i].wd, vt[i].crst, vt[i].st, vt[i].bsy, vt[i].er};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL vec%0d got %0h want %0h (rdy,we,addr,wdata,cpu_rst,start,busy,err)", i, got_v, exp_v);
      end
    end

    // Full-memory frame from RUN with random valid gaps.
    csum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      exp_w[i] = {ops[i % 8], 5'(i)};
      csum     = csum ^ exp_w[i];
    end
    exp_a  = 0;
    mon_en = 1'b1;
    step(1'b1, 8'h20, 1'b0);
    chk("len32_busy_cpurst", {30'd0, busy, cpu_rst}, 32'd3);
    for (int i = 0; i < 32; i++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, 8'hFF, 1'b0);
      step(1'b1, exp_w[i], 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("len32_before_csum", {29'd0, cpu_rst, start, busy}, {29'd0, 3'b101});
    step(1'b1, csum, 1'b0);
    chk("len32_run", {29'd0, cpu_rst, start, err}, {29'd0, 3'b010});
    chk("len32_write_count", exp_a, 32);
    begin
      int bad = 0;
      for (int i = 0; i < 32; i++) if (mem_model[i] !== exp_w[i]) bad++;
      chk("len32_mem_contents", bad, 0);
    end
    mon_en = 1'b0;

    // Held resume request gives exactly one pulse.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      pulses += int'(start);
    end
    chk("resume_hold_pulses", pulses, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("resume_release_no_start", {31'd0, start}, 32'd0);

    // Reset in the same cycle as the third word of four.
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    chk("midload_reset_outputs",
        {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, start, busy, err},
        {1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    we_snap = we_cnt;
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("midload_no_more_we", we_cnt, we_snap);
    chk("midload_partial_mem", {16'd0, mem_model[0], mem_model[1]}, 32'h5AA5);

    exp_w[0] = 8'h9A;
    exp_w[1] = 8'h0C;
    exp_a    = 0;
    mon_en   = 1'b1;
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h9A, 1'b0);
    step(1'b1, 8'h0C, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    chk("reload_run", {28'd0, cpu_rst, start, busy, err}, {28'd0, 4'b0100});
    step(1'b0, 8'h00, 1'b0);
    chk("reload_write_count", exp_a, 2);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
